load_store_unit: RTL

Memory-access initiator sitting between the CPU execute stage and the synchronous data memory. It accepts one load or store request at a time and converts byte, halfword and word accesses into word-aligned memory reads and writes. Sub-word stores use read-modify-write because the memory port has no byte enables. Loads return lane-extracted, sign- or zero-extended data on a single-cycle response pulse.

---
 rtl/load_store_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_store_unit: byte/half/word loads and stores on a word-only memory   |
// | port, with read-modify-write for sub-word stores.                        |
// | Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word requests.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module load_store_unit #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [D_WIDTH-1:0] req_wdata,
  output logic               rsp_valid,
  output logic [D_WIDTH-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_w_addr,
  output logic [D_WIDTH-1:0] mem_w_data,
  output logic               mem_re,
  output logic [A_WIDTH-1:0] mem_r_addr,
  input  logic [D_WIDTH-1:0] mem_r_data
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  logic [D_WIDTH-1:0] wr_data_q, wr_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [D_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic               req_err;
  logic [A_WIDTH-1:0] req_addr_al;
  logic [4:0]         shamt;
  logic [D_WIDTH-1:0] rd_shift;
  logic [D_WIDTH-1:0] lane_mask;
  logic [D_WIDTH-1:0] load_data;
  logic [D_WIDTH-1:0] merged;

  // Alignment is harmless in trap mode: misaligned half/word never leave IDLE there.
  always_comb begin
    req_addr_al = req_addr;
    if (req_size == SZ_HALF) begin
      req_addr_al[0] = 1'b0;
    end else if (req_size == SZ_WORD) begin
      req_addr_al[1:0] = 2'b00;
    end
  end

  always_comb begin
    req_err = (req_size == SZ_RSVD);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_size == SZ_HALF) && req_addr[0]) begin
      req_err = 1'b1;
    end
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
`endif
  end

  always_comb begin
    shamt     = {addr_q[1:0], 3'b000};
    rd_shift  = mem_r_data >> shamt;
    load_data = mem_r_data;
    lane_mask = '1;
    case (size_q)
      SZ_BYTE: begin
        load_data = {{(D_WIDTH-8){rd_shift[7] & ~uns_q}}, rd_shift[7:0]};
        lane_mask = {{(D_WIDTH-8){1'b0}}, 8'hFF} << shamt;
      end
      SZ_HALF: begin
        load_data = {{(D_WIDTH-16){rd_shift[15] & ~uns_q}}, rd_shift[15:0]};
        lane_mask = {{(D_WIDTH-16){1'b0}}, 16'hFFFF} << shamt;
      end
      default: ;
    endcase
    merged = (mem_r_data & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  end

  // Errors respond straight from the accept edge so the response cycle is
  // already an IDLE cycle and can accept the next request.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_data_d   = wr_data_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr_al;
          wdata_d = req_wdata;
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (req_we && (req_size == SZ_WORD)) begin
            wr_data_d = req_wdata;
            state_d   = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (we_q) begin
          wr_data_d = merged;
          state_d   = WR;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
          state_d     = IDLE;
        end
      end
      WR: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign mem_re     = (state_q == RD) && !rst;
  assign mem_we     = (state_q == WR) && !rst;
  assign mem_w_addr = {addr_q[A_WIDTH-1:2], 2'b00};
  assign mem_r_addr = {addr_q[A_WIDTH-1:2], 2'b00};
  assign mem_w_data = wr_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule
`default_nettype wire
